ahb_arbiter_2to1: RTL

- Two-port AHB-Lite arbiter that shares one downstream AHB-Lite slave (typically the generated register block CPU interface) between two upstream AHB masters.
- Each upstream port behaves as an AHB slave. The downstream port behaves as an AHB master.
- Every accepted upstream address phase is captured into a per-port pending register. Pending requests are serviced one at a time with round-robin priority.
- The upstream master is stalled through its HREADY until the downstream data phase completes.

---
 rtl/ahb_arbiter_2to1.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/ahb_arbiter_2to1.sv
// ahb_arbiter_2to1
// Shares one downstream AHB-Lite slave between two upstream AHB-Lite masters.
// Each accepted upstream address phase is parked in a per-port pending
// register. Pending requests are replayed downstream one at a time, with
// round-robin priority. The owning master is stalled through its hready until
// the downstream data phase completes.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   s0_* / s1_*        upstream AHB slave ports (hsel, hwrite, htrans, hsize,
//                      haddr, hwdata in; hrdata, hready, hresp out)
//   m_*                downstream AHB master port (hsel, hwrite, htrans, hsize,
//                      haddr, hwdata out; hrdata, hready, hresp in)
module ahb_arbiter_2to1 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s0_hsel,
  input  logic                  s0_hwrite,
  input  logic [1:0]            s0_htrans,
  input  logic [2:0]            s0_hsize,
  input  logic [ADDR_WIDTH-1:0] s0_haddr,
  input  logic [DATA_WIDTH-1:0] s0_hwdata,
  output logic [DATA_WIDTH-1:0] s0_hrdata,
  output logic                  s0_hready,
  output logic                  s0_hresp,
  input  logic                  s1_hsel,
  input  logic                  s1_hwrite,
  input  logic [1:0]            s1_htrans,
  input  logic [2:0]            s1_hsize,
  input  logic [ADDR_WIDTH-1:0] s1_haddr,
  input  logic [DATA_WIDTH-1:0] s1_hwdata,
  output logic [DATA_WIDTH-1:0] s1_hrdata,
  output logic                  s1_hready,
  output logic                  s1_hresp,
  output logic                  m_hsel,
  output logic                  m_hwrite,
  output logic [1:0]            m_htrans,
  output logic [2:0]            m_hsize,
  output logic [ADDR_WIDTH-1:0] m_haddr,
  output logic [DATA_WIDTH-1:0] m_hwdata,
  input  logic [DATA_WIDTH-1:0] m_hrdata,
  input  logic                  m_hready,
  input  logic                  m_hresp
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic                       gnt_q, gnt_d;
  logic                       last_q, last_d;
  logic [1:0]                 pend_q, pend_d;
  logic [1:0]                 pwrite_q, pwrite_d;
  logic [1:0][2:0]            psize_q, psize_d;
  logic [1:0][ADDR_WIDTH-1:0] paddr_q, paddr_d;

  // Upstream ports gathered into arrays so both are handled by one loop.
  logic [1:0]                 hsel_in, hwrite_in;
  logic [1:0][1:0]            htrans_in;
  logic [1:0][2:0]            hsize_in;
  logic [1:0][ADDR_WIDTH-1:0] haddr_in;
  logic [1:0][DATA_WIDTH-1:0] hwdata_in;
  logic [1:0]                 hready_int;
  logic [1:0]                 accept;
  logic                       xfer_done;

  assign hsel_in   = {s1_hsel, s0_hsel};
  assign hwrite_in = {s1_hwrite, s0_hwrite};
  assign htrans_in = {s1_htrans, s0_htrans};
  assign hsize_in  = {s1_hsize, s0_hsize};
  assign haddr_in  = {s1_haddr, s0_haddr};
  assign hwdata_in = {s1_hwdata, s0_hwdata};
  assign xfer_done = (state_q == ST_DATA) && m_hready;

  // Upstream ready: a pending port is only released on its own final data beat.
  always_comb begin
    hready_int = 2'b11;
    accept     = 2'b00;
    for (int n = 0; n < 2; n++) begin
      if (pend_q[n]) begin
        hready_int[n] = xfer_done && (gnt_q == 1'(n));
      end else begin
        hready_int[n] = 1'b1;
      end
      accept[n] = hsel_in[n] && htrans_in[n][1] && hready_int[n];
    end
  end

  // Pending registers: a new acceptance wins over the clear, so a port can
  // re-arm in the very cycle its previous response completes.
  always_comb begin
    pend_d   = pend_q;
    pwrite_d = pwrite_q;
    psize_d  = psize_q;
    paddr_d  = paddr_q;
    for (int n = 0; n < 2; n++) begin
      if (accept[n]) begin
        pend_d[n]   = 1'b1;
        pwrite_d[n] = hwrite_in[n];
        psize_d[n]  = hsize_in[n];
        paddr_d[n]  = haddr_in[n];
      end else if (xfer_done && (gnt_q == 1'(n))) begin
        pend_d[n] = 1'b0;
      end else begin
        pend_d[n] = pend_q[n];
      end
    end
  end

  // Grant FSM next state; on a tie the port not granted last time wins.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (pend_q != 2'b00) begin
          if (pend_q == 2'b11) begin
            gnt_d = ~last_q;
          end else begin
            // exactly one pending: bit 1 set means port 1
            gnt_d = pend_q[1];
          end
          last_d  = gnt_d;
          state_d = ST_ADDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (m_hready) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (m_hready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DATA;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode; reset forces the idle values even before the flops settle.
  always_comb begin
    s0_hready = 1'b1;
    s1_hready = 1'b1;
    s0_hresp  = 1'b0;
    s1_hresp  = 1'b0;
    s0_hrdata = {DATA_WIDTH{1'b0}};
    s1_hrdata = {DATA_WIDTH{1'b0}};
    m_hsel    = 1'b0;
    m_htrans  = 2'b00;
    m_hwrite  = 1'b0;
    m_hsize   = 3'b000;
    m_haddr   = {ADDR_WIDTH{1'b0}};
    m_hwdata  = {DATA_WIDTH{1'b0}};
    if (!rst) begin
      s0_hready = hready_int[0];
      s1_hready = hready_int[1];
      case (state_q)
        ST_ADDR: begin
          m_hsel   = 1'b1;
          m_htrans = 2'b10;
          m_hwrite = pwrite_q[gnt_q];
          m_hsize  = psize_q[gnt_q];
          m_haddr  = paddr_q[gnt_q];
        end
        ST_DATA: begin
          // upstream master holds hwdata while stalled, so pass it straight on
          m_hwdata = hwdata_in[gnt_q];
          if (gnt_q) begin
            s1_hrdata = m_hrdata;
            s1_hresp  = m_hresp;
          end else begin
            s0_hrdata = m_hrdata;
            s0_hresp  = m_hresp;
          end
        end
        default: begin
          m_hsel = 1'b0;
        end
      endcase
    end else begin
      s0_hready = 1'b1;
      s1_hready = 1'b1;
    end
  end

  // State and pending registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      pend_q   <= 2'b00;
      pwrite_q <= 2'b00;
      psize_q  <= {2{3'b000}};
      paddr_q  <= {2{{ADDR_WIDTH{1'b0}}}};
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      pend_q   <= pend_d;
      pwrite_q <= pwrite_d;
      psize_q  <= psize_d;
      paddr_q  <= paddr_d;
    end
  end

endmodule
